// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM states, counter constants and parameter legality check for gshare_bp.
package bp_pkg;
  typedef enum logic {INIT, RUN} bp_state_e;
  localparam logic [1:0] WEAK_NT = 2'b01;
  localparam logic [1:0] TAKEN_THRESH = 2'd2;
  function automatic bit params_ok(int dbits, int ghr_bits, int pht_bits, int btb_bits, int tag_bits);
    return ghr_bits >= 2 && ghr_bits <= pht_bits && pht_bits + 2 <= dbits && tag_bits + btb_bits + 2 <= dbits;
  endfunction
endpackage

// File: rtl/bp_btb.sv
// bp_btb: tagged direct-mapped branch target buffer, async valid clear.
//   clk, reset (async active-low) | i_rd_pc -> o_hit, o_target (combinational read)
//   i_wr_en, i_wr_pc, i_wr_target : allocate/overwrite slot of i_wr_pc at next posedge
module bp_btb #(
  parameter int DBITS    = 32,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] i_rd_pc,
  output logic             o_hit,
  output logic [DBITS-1:0] o_target,
  input  logic             i_wr_en,
  input  logic [DBITS-1:0] i_wr_pc,
  input  logic [DBITS-1:0] i_wr_target
);
  localparam int N = 2 ** IDX_BITS;
  logic [N-1:0]        r_valid;
  logic [TAG_BITS-1:0] r_tag [N];
  logic [DBITS-1:0]    r_target [N];
  logic [IDX_BITS-1:0] w_rd_slot, w_wr_slot;
  logic [TAG_BITS-1:0] w_rd_tag, w_wr_tag;
  logic                w_unused;
  assign w_rd_slot = i_rd_pc[IDX_BITS+1:2];
  assign w_wr_slot = i_wr_pc[IDX_BITS+1:2];
  assign w_rd_tag  = i_rd_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign w_wr_tag  = i_wr_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign o_hit     = r_valid[w_rd_slot] && r_tag[w_rd_slot] == w_rd_tag;
  assign o_target  = r_target[w_rd_slot];
  // PC bits outside slot/tag intentionally ignored
  assign w_unused  = ^{i_rd_pc, i_wr_pc};
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_valid <= '0;
    else if (i_wr_en) r_valid[w_wr_slot] <= 1'b1;
  always_ff @(posedge clk)
    if (i_wr_en) begin
      r_tag[w_wr_slot]    <= w_wr_tag;
      r_target[w_wr_slot] <= i_wr_target;
    end
endmodule

// File: rtl/gshare_bp.sv
// gshare_bp: gshare direction predictor (GHR xor PC -> 2-bit PHT) with BTB targets.
//   clk, reset (async active-low)
//   lookup_valid, lookup_pc -> pred_taken, pred_target, pred_pht_idx, pred_ghr (combinational)
//   bp_ready : high once the PHT init walk completes
//   upd_* : resolution from execute (PHT train, BTB allocate on taken, GHR repair on mispredict)
module gshare_bp
  import bp_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int GHR_BITS     = 8,
  parameter int PHT_IDX_BITS = 8,
  parameter int BTB_IDX_BITS = 4,
  parameter int TAG_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lookup_valid,
  input  logic [DBITS-1:0]        lookup_pc,
  output logic                    pred_taken,
  output logic [DBITS-1:0]        pred_target,
  output logic [PHT_IDX_BITS-1:0] pred_pht_idx,
  output logic [GHR_BITS-1:0]     pred_ghr,
  output logic                    bp_ready,
  input  logic                    upd_valid,
  input  logic                    upd_taken,
  input  logic                    upd_mispredict,
  input  logic [PHT_IDX_BITS-1:0] upd_pht_idx,
  input  logic [GHR_BITS-1:0]     upd_ghr,
  input  logic [DBITS-1:0]        upd_pc,
  input  logic [DBITS-1:0]        upd_target
);
  localparam int PHT_N = 2 ** PHT_IDX_BITS;
  if (!params_ok(DBITS, GHR_BITS, PHT_IDX_BITS, BTB_IDX_BITS, TAG_BITS)) begin : g_bad_params
    $error("gshare_bp: illegal parameter combination");
  end
  bp_state_e               r_state;
  logic                    r_ready;
  logic [PHT_IDX_BITS-1:0] r_init_idx;
  logic [GHR_BITS-1:0]     r_ghr;
  logic [1:0]              r_pht [PHT_N];
  logic [PHT_IDX_BITS-1:0] w_idx;
  logic [1:0]              w_ctr;
  logic                    w_hit, w_btb_we, w_unused;
  logic [DBITS-1:0]        w_btb_target;
  assign w_idx        = lookup_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(r_ghr);
  assign pred_taken   = r_ready && w_hit && r_pht[w_idx] >= TAKEN_THRESH;
  assign pred_target  = pred_taken ? w_btb_target : lookup_pc + DBITS'(4);
  assign pred_pht_idx = w_idx;
  assign pred_ghr     = r_ghr;
  assign bp_ready     = r_ready;
  assign w_ctr        = r_pht[upd_pht_idx];
  assign w_btb_we     = r_state == RUN && upd_valid && upd_taken;
  // oldest history bit falls off on repair
  assign w_unused     = upd_ghr[GHR_BITS-1];
  bp_btb #(.DBITS(DBITS), .IDX_BITS(BTB_IDX_BITS), .TAG_BITS(TAG_BITS)) u_btb (
    .clk(clk), .reset(reset),
    .i_rd_pc(lookup_pc), .o_hit(w_hit), .o_target(w_btb_target),
    .i_wr_en(w_btb_we), .i_wr_pc(upd_pc), .i_wr_target(upd_target)
  );
  // Mispredict repair beats the speculative shift: decode is being flushed.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= INIT;
      r_ready    <= 1'b0;
      r_init_idx <= '0;
      r_ghr      <= '0;
    end else if (r_state == INIT) begin
      r_init_idx <= r_init_idx + 1'b1;
      if (&r_init_idx) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end else if (upd_valid && upd_mispredict) r_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
    else if (lookup_valid) r_ghr <= {r_ghr[GHR_BITS-2:0], pred_taken};
  always_ff @(posedge clk)
    if (r_state == INIT) r_pht[r_init_idx] <= WEAK_NT;
    else if (upd_valid) r_pht[upd_pht_idx] <= upd_taken ? (&w_ctr ? w_ctr : w_ctr + 2'd1)
                                                        : (|w_ctr ? w_ctr - 2'd1 : w_ctr);
endmodule

// File: tb/tb_gshare_bp.sv
// tb_gshare_bp: directed + randomized check of gshare_bp against a behavioural model.
module tb_gshare_bp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_pht_idx;
  logic [7:0]  pred_ghr;
  logic        bp_ready;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredict = 1'b0;
  logic [7:0]  upd_pht_idx = '0, upd_ghr = '0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  int n_tests = 0, n_fail = 0;

  gshare_bp dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_pht_idx(pred_pht_idx), .pred_ghr(pred_ghr), .bp_ready(bp_ready),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .upd_pht_idx(upd_pht_idx), .upd_ghr(upd_ghr), .upd_pc(upd_pc), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  // behavioural model: plain arrays indexed by the rules of the predictor
  int          m_pht [256];
  bit          m_v [16];
  int          m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ghr = 0, m_cnt = 0;
  bit          m_ready = 0;

  function automatic void m_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg, output int ix);
    int s;
    ix = int'((pc >> 2) & 32'd255) ^ m_ghr;
    s  = int'((pc >> 2) & 32'd15);
    t  = m_ready && m_v[s] && m_tag[s] == int'((pc >> 6) & 32'hFFFF) && m_pht[ix] >= 2;
    tg = t ? m_tgt[s] : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic        t;
    logic [31:0] tg;
    int          ix, s;
    if (!reset) begin
      m_ready = 0;
      m_cnt   = 0;
      m_ghr   = 0;
      foreach (m_v[i]) m_v[i] = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 256) begin
        m_ready = 1;
        foreach (m_pht[i]) m_pht[i] = 1;
      end
    end else begin
      m_pred(lookup_pc, t, tg, ix);
      if (upd_valid && upd_mispredict) m_ghr = (int'(upd_ghr) * 2 + int'(upd_taken)) % 256;
      else if (lookup_valid) m_ghr = (m_ghr * 2 + int'(t)) % 256;
      if (upd_valid) begin
        if (upd_taken) m_pht[upd_pht_idx] = (m_pht[upd_pht_idx] == 3) ? 3 : m_pht[upd_pht_idx] + 1;
        else m_pht[upd_pht_idx] = (m_pht[upd_pht_idx] == 0) ? 0 : m_pht[upd_pht_idx] - 1;
      end
      if (upd_valid && upd_taken) begin
        s = int'((upd_pc >> 2) & 32'd15);
        m_v[s]   = 1;
        m_tag[s] = int'((upd_pc >> 6) & 32'hFFFF);
        m_tgt[s] = upd_target;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic        t;
    logic [31:0] tg;
    int          ix;
    m_pred(lookup_pc, t, tg, ix);
    chk("model_ready", 32'(bp_ready), 32'(m_ready));
    chk("model_taken", 32'(pred_taken), 32'(t));
    chk("model_target", pred_target, tg);
    chk("model_idx", 32'(pred_pht_idx), ix);
    chk("model_ghr", 32'(pred_ghr), m_ghr);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    lookup_valid   = 1'b0;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic upd(input logic [7:0] idx, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid = 1'b1; upd_taken = tk; upd_mispredict = 1'b0;
    upd_pht_idx = idx; upd_pc = pc; upd_target = tgt; upd_ghr = 8'h00;
    cyc();
    upd_valid = 1'b0;
  endtask

  // lookup 0x100 held valid during INIT: must predict fall-through and leave GHR at 0
  task automatic wait_ready(output int lat);
    lat = -1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) begin
        chk("init_lookup_taken", 32'(pred_taken), 32'h0);
        chk("init_lookup_target", pred_target, 32'h104);
      end
      if (bp_ready) begin
        lat = k;
        break;
      end
    end
    idle();
    #1;
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] p;
    p = 32'($urandom_range(0, 31)) << 2;
    if ($urandom % 4 == 0) p = p | 32'h10000;
    if ($urandom % 50 == 0) p = 32'hFFFF_FFFC;
    return p;
  endfunction

  initial begin
    int lat;
    repeat (3) cyc();
    #1;
    chk("reset_ready", 32'(bp_ready), 32'h0);
    chk("reset_ghr", 32'(pred_ghr), 32'h0);
    reset = 1'b1;
    wait_ready(lat);
    chk("init_latency", lat, 256);

    lookup_pc = 32'h100;
    #1;
    chk("cold_taken", 32'(pred_taken), 32'h0);
    chk("cold_target", pred_target, 32'h104);
    chk("cold_idx", 32'(pred_pht_idx), 32'h40);
    upd(8'h40, 32'h100, 32'h200, 1'b1);
    upd(8'h40, 32'h100, 32'h200, 1'b1);
    #1;
    chk("trained_taken", 32'(pred_taken), 32'h1);
    chk("trained_target", pred_target, 32'h200);
    repeat (3) upd(8'h40, 32'h100, 32'h200, 1'b1);
    upd(8'h40, 32'h100, 32'h200, 1'b0);
    #1;
    chk("sat_one_nt_taken", 32'(pred_taken), 32'h1);
    upd(8'h40, 32'h100, 32'h200, 1'b0);
    #1;
    chk("sat_two_nt_taken", 32'(pred_taken), 32'h0);
    chk("sat_two_nt_target", pred_target, 32'h104);

    upd(8'h40, 32'h100, 32'h200, 1'b1);
    upd(8'h42, 32'h100, 32'h200, 1'b1);
    lookup_valid = 1'b1;
    lookup_pc = 32'h100;
    #1;
    chk("ghr_look1", 32'(pred_taken), 32'h1);
    cyc();
    lookup_pc = 32'h300;
    #1;
    chk("ghr_look2", 32'(pred_taken), 32'h0);
    cyc();
    lookup_pc = 32'h100;
    #1;
    chk("ghr_look3", 32'(pred_taken), 32'h1);
    cyc();
    lookup_valid = 1'b0;
    #1;
    chk("ghr_after3", 32'(pred_ghr), 32'h05);

    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_taken = 1'b0;
    upd_ghr = 8'h0F; upd_pht_idx = 8'h00; upd_pc = 32'h104; upd_target = 32'h0;
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    cyc();
    idle();
    #1;
    chk("ghr_repair", 32'(pred_ghr), 32'h1E);

    upd(8'h5E, 32'h100, 32'h200, 1'b1);
    upd(8'h5E, 32'h100, 32'h200, 1'b1);
    lookup_pc = 32'h100;
    #1;
    chk("alias_pre_idx", 32'(pred_pht_idx), 32'h5E);
    chk("alias_pre_target", pred_target, 32'h200);
    upd(8'h11, 32'h10100, 32'h300, 1'b1);
    lookup_pc = 32'h100;
    #1;
    chk("alias_old_taken", 32'(pred_taken), 32'h0);
    chk("alias_old_target", pred_target, 32'h104);
    lookup_pc = 32'h10100;
    #1;
    chk("alias_new_target", pred_target, 32'h300);

    reset = 1'b0;
    #1;
    chk("midrun_ready", 32'(bp_ready), 32'h0);
    chk("midrun_ghr", 32'(pred_ghr), 32'h0);
    cyc();
    cyc();
    reset = 1'b1;
    wait_ready(lat);
    chk("reinit_latency", lat, 256);
    upd(8'h40, 32'h104, 32'h500, 1'b1);
    upd(8'h40, 32'h104, 32'h500, 1'b1);
    lookup_pc = 32'h10100;
    #1;
    chk("btb_cleared_taken", 32'(pred_taken), 32'h0);
    chk("btb_cleared_target", pred_target, 32'h10104);

    for (int i = 0; i < 3000; i++) begin
      lookup_valid   = 1'($urandom % 2);
      lookup_pc      = pick_pc();
      upd_valid      = 1'($urandom % 2);
      upd_taken      = 1'($urandom % 2);
      upd_mispredict = ($urandom % 5) == 0;
      upd_pht_idx    = 8'($urandom);
      upd_ghr        = 8'($urandom);
      upd_pc         = pick_pc();
      upd_target     = $urandom & ~32'h3;
      cyc();
    end
    idle();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gshare_bp.md
# gshare_bp

Parametrised gshare branch predictor: global history register (GHR) XOR PC indexes a table of 2-bit saturating counters (PHT), and a tagged, direct-mapped branch target buffer (BTB) supplies targets. Sits beside the decode stage, which looks up a prediction; the execute/address stage sends resolution updates back to it. It replaces the fixed 8-bit/16-entry predictor with configurable sizes, speculative history with mispredict repair, BTB allocation on taken branches only, and a sequenced PHT initialisation after reset.

## Interface
- DBITS, 32, data/PC width
- GHR_BITS, 8, global history length; must be ≤ PHT_IDX_BITS
- PHT_IDX_BITS, 8, log2 PHT entries
- BTB_IDX_BITS, 4, log2 BTB entries
- TAG_BITS, 16, BTB tag width; TAG_BITS+BTB_IDX_BITS+2 ≤ DBITS

- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-low
- lookup_valid  in  1  decode accepts a branch this cycle (asserted only when the DE latch advances)
- lookup_pc  in  DBITS  PC of the instruction in decode
- pred_taken  out  1  predicted taken
- pred_target  out  DBITS  predicted next PC
- pred_pht_idx  out  PHT_IDX_BITS  PHT index used, carried down the pipe
- pred_ghr  out  GHR_BITS  GHR snapshot before this lookup, carried down the pipe
- bp_ready  out  1  high once PHT initialisation completes
- upd_valid  in  1  a branch resolved this cycle
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  direction or target mispredicted
- upd_pht_idx  in  PHT_IDX_BITS  index returned from lookup
- upd_ghr  in  GHR_BITS  GHR snapshot returned from lookup
- upd_pc  in  DBITS  branch PC
- upd_target  in  DBITS  actual taken target

## Operation
- Index: idx = lookup_pc[PHT_IDX_BITS+1:2] XOR zero-extended GHR.
- BTB slot = lookup_pc[BTB_IDX_BITS+1:2]; tag = lookup_pc[TAG_BITS+BTB_IDX_BITS+1:BTB_IDX_BITS+2]; hit = valid && tag match.
- pred_taken = bp_ready && hit && PHT[idx] ≥ 2; pred_target = pred_taken ? BTB target : lookup_pc + 4 (mod 2^DBITS). Outputs are combinational from lookup_pc and current state.
- FSM states: INIT, RUN.
  - INIT: counter walks 0 … 2^PHT_IDX_BITS−1, writing 2'b01 (weakly not-taken) to one entry per cycle; at last index → RUN. bp_ready=0; updates and lookups ignored; GHR held 0.
  - RUN: bp_ready=1.
- GHR in RUN, priority order: upd_valid && upd_mispredict → GHR ← {upd_ghr[GHR_BITS−2:0], upd_taken}; else lookup_valid → GHR ← {GHR[GHR_BITS−2:0], pred_taken}; else hold.
- PHT update on upd_valid: entry upd_pht_idx increments if upd_taken, decrements otherwise; saturates at 3 and 0.
- BTB update on upd_valid && upd_taken: slot from upd_pc ← {valid=1, tag(upd_pc), upd_target}. Not-taken updates leave the BTB unchanged.

## Timing
- Reset assertion (async): state ← INIT, init counter ← 0, GHR ← 0, all BTB valid ← 0, bp_ready ← 0 immediately. PHT contents are undefined until INIT completes.
- Init latency: bp_ready rises 2^PHT_IDX_BITS cycles after the first posedge following reset deassertion (256 at defaults).
- Reset mid-INIT or mid-RUN: restarts INIT from index 0.
- Lookup is zero-latency (same cycle). Lookup and update writes land at the next posedge.
- An update and a lookup to the same PHT entry or BTB slot in one cycle: the lookup sees the old value.
- A mispredict and a lookup in the same cycle: GHR repair wins; the lookup's shift is discarded, because decode is flushed.

## Structure
- Package bp_pkg holds the FSM state enum {INIT, RUN}, the counter constants WEAK_NT=2'b01 and TAKEN_THRESH=2, and the parameter legality checks.
- Sub-module bp_btb implements the tagged, direct-mapped BTB with async valid clear. PHT, GHR and FSM live in gshare_bp.

## Test plan
- Reset low 3 cycles, then high: bp_ready=0 for exactly 256 cycles, then 1. Any lookup during INIT gives pred_taken=0, pred_target=pc+4.
- After init, lookup pc=0x100 → pred_taken=0, target=0x104. Two taken updates for that idx with upd_target=0x200 → next lookup (same GHR) pred_taken=1, target=0x200.
- Saturation: 5 taken updates on one idx → counter 3. A single not-taken update → still predicts taken (counter 2).
- GHR: three lookups predicting 1,0,1 → pred_ghr=8'b101 on the 4th. Mispredict with upd_ghr=8'h0F, upd_taken=0 issued with a simultaneous lookup → GHR=8'h1E next cycle.
- BTB alias: taken update at pc=0x100 then at pc=0x10100 (same slot, different tag) → lookup 0x100 misses, target=0x104.
- Assert reset mid-RUN: BTB valid cleared, GHR=0, bp_ready=0 asynchronously, and INIT replays the full 256 cycles.
